// File: rtl/full_subtractor_mux.sv
// Registered ripple-borrow subtractor built from mux-based full-subtractor cells.
// Produces {bout, diff} = a - b - bin one clock after a valid input.
module full_subtractor_mux #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // Difference cell: 4:1 mux selected by {b, borrow-in}.
    function automatic logic cell_diff(input logic ai, input logic bi, input logic ci);
        logic d;
        case ({bi, ci})
            2'b00:   d = ai;
            2'b01:   d = ~ai;
            2'b10:   d = ~ai;
            default: d = ai;
        endcase
        return d;
    endfunction

    // Borrow cell: 4:1 mux selected by {b, borrow-in}.
    function automatic logic cell_borrow(input logic ai, input logic bi, input logic ci);
        logic br;
        case ({bi, ci})
            2'b00:   br = 1'b0;
            2'b01:   br = ~ai;
            2'b10:   br = ~ai;
            default: br = 1'b1;
        endcase
        return br;
    endfunction

    logic [WIDTH-1:0] diff_p0;
    logic             bout_p0;
    logic             vld_p0;

    logic [WIDTH-1:0] diff_p1;
    logic             bout_p1;
    logic             vld_p1;

    // Stage p0: combinational ripple, LSB to MSB.
    always_comb begin
        logic borrow;
        borrow  = bin;
        diff_p0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff_p0[i] = cell_diff(a[i], b[i], borrow);
            borrow     = cell_borrow(a[i], b[i], borrow);
        end
        bout_p0 = borrow;
        vld_p0  = in_valid;
    end

    // Stage p1: output register; result holds while input is not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_p1 <= '0;
            bout_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                diff_p1 <= diff_p0;
                bout_p1 <= bout_p0;
            end
        end
    end

    assign diff      = diff_p1;
    assign bout      = bout_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_full_subtractor_mux.sv
// Bench for full_subtractor_mux: a 1-bit instance checked against the truth table
// and an 8-bit instance checked against a - b - bin, through scoreboard queues.
module tb_full_subtractor_mux;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       bo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
    logic       out_valid1, diff1, bout1;

    logic       in_valid8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       out_valid8, bout8;
    logic [7:0] diff8;

    int checks = 0;
    int errors = 0;

    exp_t q1[$];
    exp_t q8[$];
    logic [7:0] m8_d = '0;
    logic       m8_b = 1'b0;
    logic       m1_d = 1'b0;
    logic       m1_b = 1'b0;

    // {diff, bout} indexed by {bin, b, a}
    logic [1:0] tt [0:7] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b11, 2'b00, 2'b01, 2'b11};

    full_subtractor_mux #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
        .a(a1), .b(b1), .bin(bin1),
        .out_valid(out_valid1), .diff(diff1), .bout(bout1)
    );

    full_subtractor_mux #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8),
        .a(a8), .b(b8), .bin(bin8),
        .out_valid(out_valid8), .diff(diff8), .bout(bout8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step1(input logic v, input logic [2:0] idx);
        exp_t e;
        in_valid1 = v;
        {bin1, b1, a1} = idx;
        if (v) {m1_d, m1_b} = tt[idx];
        e.v = v; e.d = {7'd0, m1_d}; e.bo = m1_b;
        q1.push_back(e);
        @(posedge clk);
        #1;
        if (q1.size() == 0) begin
            check("w1_queue_empty", 9'd1, 9'd0);
        end else begin
            e = q1.pop_front();
            check($sformatf("w1_diff_%0d", idx), {8'd0, diff1}, {8'd0, e.d[0]});
            check($sformatf("w1_bout_%0d", idx), {8'd0, bout1}, {8'd0, e.bo});
            check($sformatf("w1_vld_%0d", idx), {8'd0, out_valid1}, {8'd0, e.v});
        end
    endtask

    task automatic step8(input string tag, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic bi);
        exp_t e;
        logic [8:0] r;
        in_valid8 = v;
        a8 = a; b8 = b; bin8 = bi;
        r = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        if (v) begin
            m8_d = r[7:0];
            m8_b = r[8];
        end
        e.v = v; e.d = m8_d; e.bo = m8_b;
        q8.push_back(e);
        @(posedge clk);
        #1;
        if (q8.size() == 0) begin
            check("w8_queue_empty", 9'd1, 9'd0);
        end else begin
            e = q8.pop_front();
            check({tag, "_diff"}, {1'b0, diff8}, {1'b0, e.d});
            check({tag, "_bout"}, {8'd0, bout8}, {8'd0, e.bo});
            check({tag, "_vld"}, {8'd0, out_valid8}, {8'd0, e.v});
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_diff8", {1'b0, diff8}, 9'd0);
        check("rst_bout8", {8'd0, bout8}, 9'd0);
        check("rst_vld8", {8'd0, out_valid8}, 9'd0);
        check("rst_vld1", {8'd0, out_valid1}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 1-bit truth table
        for (int i = 0; i < 8; i++) step1(1'b1, i[2:0]);
        in_valid1 = 1'b0;

        // Directed 8-bit vectors
        step8("sub_5_3", 1'b1, 8'h05, 8'h03, 1'b0);
        step8("sub_0_1", 1'b1, 8'h00, 8'h01, 1'b0);
        step8("sub_80_80_b", 1'b1, 8'h80, 8'h80, 1'b1);

        // Valid gating: result must hold, out_valid low
        step8("gate0", 1'b0, 8'h12, 8'h34, 1'b0);
        step8("gate1", 1'b0, 8'hA5, 8'h01, 1'b1);
        step8("gate2", 1'b0, 8'h00, 8'h00, 1'b0);

        // Reload 0xFF / borrow, then async reset between edges
        step8("pre_rst", 1'b1, 8'h80, 8'h80, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_diff8", {1'b0, diff8}, 9'd0);
        check("arst_bout8", {8'd0, bout8}, 9'd0);
        check("arst_vld8", {8'd0, out_valid8}, 9'd0);
        m8_d = '0;
        m8_b = 1'b0;
        in_valid8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back random vectors
        for (int k = 0; k < 16; k++)
            step8($sformatf("rnd%0d", k), 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        step8("rnd_tail", 1'b0, 8'h00, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/full_subtractor_mux.md
# full_subtractor_mux

Registered ripple-borrow subtractor built from multiplexer-based full-subtractor cells. Computes a − b − bin over a configurable word width and presents difference and borrow-out one clock after a valid input. Used wherever a small synchronous subtract stage is needed; with WIDTH=1 it is a registered single-bit full subtractor.

## Interface
- WIDTH, default 1: operand width in bits; legal range 1..32.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  qualifies a, b, bin in the current cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in to bit 0.
- out_valid  output  1  diff/bout hold a fresh result.
- diff  output  WIDTH  registered difference, (a − b − bin) mod 2^WIDTH.
- bout  output  1  registered borrow-out of the MSB cell.

## Operation
- Per-bit cell i, select s = {b[i], c[i]}, where c[0] = bin and c[i+1] = borrow of cell i.
- Cell difference is a 4:1 mux on s: 00→a[i], 01→~a[i], 10→~a[i], 11→a[i]. This equals a[i]^b[i]^c[i].
- Cell borrow is a 4:1 mux on s: 00→0, 01→~a[i], 10→~a[i], 11→1. This equals (~a&b)|(~a&c)|(b&c).
- Cells chain LSB to MSB as a combinational ripple. bout is the borrow out of cell WIDTH−1.
- Single-bit truth table, listed as {bin,b,a}→{diff,bout}:
  - 000→00, 001→10, 010→11, 011→00
  - 100→11, 101→00, 110→01, 111→11
- Arithmetic identity: {bout, diff} = a − b − bin in (WIDTH+1)-bit two's complement. bout=1 iff a < b + bin, unsigned.
- Registering when in_valid=1 at a clock edge:
  - diff and bout load the combinational result.
  - out_valid goes to 1.
- When in_valid=0 at a clock edge:
  - diff and bout hold their previous values.
  - out_valid goes to 0.
- No backpressure. A new result may be accepted every cycle.

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is 1 result per cycle.
- Reset (rst_n=0) immediately, without waiting for a clock, forces:
  - diff = 0
  - bout = 0
  - out_valid = 0
- Reset mid-operation discards any in-flight result.
- The first edge after rst_n rises samples normally.
- Critical path is a WIDTH-deep mux ripple. No internal pipelining.
- Outputs are driven only from flops; no combinational path from inputs to outputs.

## Test plan
- Exhaustive single bit, WIDTH=1: sweep {bin,b,a} from 000 to 111 with in_valid=1. Each cycle later, {diff,bout} must match the truth table above (e.g. 010→diff=1, bout=1; 110→diff=0, bout=1).
- Multi-bit, WIDTH=8:
  - a=0x05, b=0x03, bin=0 → diff=0x02, bout=0.
  - a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1.
  - a=0x80, b=0x80, bin=1 → diff=0xFF, bout=1.
- Valid gating: drive a result, then hold in_valid=0 for 3 cycles with changing a/b. diff and bout must stay unchanged and out_valid must be 0.
- Async reset: assert rst_n=0 between clock edges while diff=0xFF and bout=1. The outputs must be 0 before the next edge, and out_valid must be 0.
- Back-to-back: apply 16 random vectors on consecutive cycles with in_valid=1. Output k must equal vector k−1 per the arithmetic identity, and out_valid must stay 1.
